// File: rtl/pipe1_rr_sched_pkg.sv
// Shared definitions for the round-robin scheduled 3-stage arithmetic pipeline:
// default operand width, requester limit, elaboration helper and stage-1 payload.
package pipe1_pkg;

    localparam int N_DEF    = 8;
    localparam int NREQ_MAX = 8;

    // Ceiling log2, used to size tags from a requester count.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            res++;
        end
        return res;
    endfunction

    localparam int TAG_MAX_W = clog2(NREQ_MAX);

    // Stage-1 payload: the two partial sums, the D operand carried forward to
    // the multiply, and the issuing requester index (widest possible tag).
    typedef struct packed {
        logic [N_DEF-1:0]     x1;
        logic [N_DEF-1:0]     x2;
        logic [N_DEF-1:0]     d;
        logic [TAG_MAX_W-1:0] tag;
    } stage_pay_t;

endpackage

// File: rtl/pipe1_rr_sched_if.sv
// Requester and result-consumer handshake bundle for pipe1_rr_sched.
// master: requester agents plus the consumer; slave: the scheduler.
interface pipe1_rr_sched_if #(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int TAGW = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ*N-1:0] req_c;
    logic [NREQ*N-1:0] req_d;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_f;
    logic [TAGW-1:0]   out_tag;

    modport master (
        output req_valid, req_a, req_b, req_c, req_d, out_ready,
        input  req_ready, out_valid, out_f, out_tag
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, req_d, out_ready,
        output req_ready, out_valid, out_f, out_tag
    );
endinterface

// File: rtl/pipe1_rr_sched_dp_en.sv
// Three-stage arithmetic datapath with one shared enable.
// S1 holds x1/x2/D/tag, S2 holds x3=x1+x2 with D/tag, S3 holds F=x3*D with tag.
// Valid bits shift alongside; all arithmetic wraps modulo 2^N_DEF.
module pipe1_dp_en
    import pipe1_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    input  stage_pay_t           in_pay,
    output logic                 v1,
    output logic                 v2,
    output logic                 v3,
    output logic [N_DEF-1:0]     f,
    output logic [TAG_MAX_W-1:0] tag
);

    stage_pay_t           s1;
    logic [N_DEF-1:0]     x3;
    logic [N_DEF-1:0]     d2;
    logic [TAG_MAX_W-1:0] tag2;

    // Whole pipe moves together on en; otherwise every stage holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            s1   <= '0;
            x3   <= '0;
            d2   <= '0;
            tag2 <= '0;
            f    <= '0;
            tag  <= '0;
        end else if (en) begin
            v1   <= in_valid;
            s1   <= in_pay;
            v2   <= v1;
            x3   <= s1.x1 + s1.x2;
            d2   <= s1.d;
            tag2 <= s1.tag;
            v3   <= v2;
            f    <= x3 * d2;
            tag  <= tag2;
        end
    end

endmodule

// File: rtl/pipe1_rr_sched.sv
// Round-robin scheduler feeding one shared 3-stage arithmetic pipeline.
// Arbitrates the requesters, issues at most one operand set per cycle, tags
// each item with its requester index and stalls the whole pipe on backpressure.
// Optional stall-cycle counter: define PIPE1_RR_SCHED_PERF_EN to build it;
// otherwise perf_cnt is tied to zero.
module pipe1_rr_sched
    import pipe1_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = 4,
    parameter int TAGW = 2,
    parameter int CNTW = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe1_rr_sched_if.slave  bus,
    output logic             busy,
    output logic [CNTW-1:0]  perf_cnt
);

    if (TAGW != clog2(NREQ)) begin : g_tagw_chk
        $error("TAGW must equal clog2(NREQ)");
    end
    if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_nreq_chk
        $error("NREQ must be in 2..NREQ_MAX");
    end
    if (N != N_DEF) begin : g_n_chk
        $error("N must match the stage payload width N_DEF");
    end

    logic [TAGW-1:0]      ptr;
    logic [TAGW-1:0]      gnt_idx;
    logic [TAGW-1:0]      cand_idx;
    logic                 gnt_found;
    logic                 advance;
    logic                 issue;
    int                   cand;
    logic [N-1:0]         a_sel, b_sel, c_sel, d_sel;
    stage_pay_t           pay;
    logic                 dp_v1, dp_v2, dp_v3;
    logic [TAG_MAX_W-1:0] dp_tag;
    logic                 unused_tag_hi;

    assign advance = !dp_v3 || bus.out_ready;
    assign issue   = advance && gnt_found;

    // First requesting index at or after ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = TAGW'(cand);
            if (!gnt_found && bus.req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    // Accept strobe goes only to the granted requester, and only when the pipe moves.
    always_comb begin
        bus.req_ready = '0;
        if (issue) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        c_sel = '0;
        d_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == TAGW'(k)) begin
                a_sel = bus.req_a[k*N +: N];
                b_sel = bus.req_b[k*N +: N];
                c_sel = bus.req_c[k*N +: N];
                d_sel = bus.req_d[k*N +: N];
            end
        end
    end

    // Stage-1 payload is built here so the datapath sees ready-made partial sums.
    always_comb begin
        pay     = '0;
        pay.x1  = a_sel + b_sel;
        pay.x2  = c_sel - d_sel;
        pay.d   = d_sel;
        pay.tag = TAG_MAX_W'(gnt_idx);
    end

    // Pointer moves past the winner on each issue; holds on idle or stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (gnt_idx == TAGW'(NREQ - 1)) ? '0 : gnt_idx + TAGW'(1);
        end
    end

    pipe1_dp_en u_dp (
        .clk      (clk),
        .rst      (rst),
        .en       (advance),
        .in_valid (gnt_found),
        .in_pay   (pay),
        .v1       (dp_v1),
        .v2       (dp_v2),
        .v3       (dp_v3),
        .f        (bus.out_f),
        .tag      (dp_tag)
    );

    assign bus.out_valid = dp_v3;
    assign bus.out_tag   = dp_tag[TAGW-1:0];
    // Tag bits above TAGW are always zero for this NREQ.
    assign unused_tag_hi = ^(dp_tag >> TAGW);
    assign busy          = dp_v1 || dp_v2 || dp_v3 || (|bus.req_valid);

`ifdef PIPE1_RR_SCHED_PERF_EN
    logic [CNTW-1:0] stall_cnt;

    // Count cycles where a result waits on the consumer; saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (dp_v3 && !bus.out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNTW'(1);
        end
    end

    assign perf_cnt = stall_cnt;
`else
    assign perf_cnt = '0;
`endif

endmodule
